alu_rtype_control_unit: RTL

//  Hardwired control sequencer, directly upstream of Datapath. Replaces bench-driven T0..T5 sequencing.

---
 rtl/alu_rtype_control_unit_if.sv | 29 ++
 rtl/alu_rtype_control_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_rtype_control_unit_if.sv
// Control-unit <-> Datapath signal bundle.
//   master : control sequencer. It drives the strobes, the selects, ALU_Control,
//            run and illegal, and it receives IR and stop.
//   slave  : Datapath / environment side. It drives IR and stop, and it
//            receives everything else.
interface alu_rtype_control_unit_if;
  logic [31:0] IR;
  logic        stop;
  logic        PCout, Zlowout, MDRout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin;
  logic        Read;
  logic        Gra, Grb, Grc;
  logic        Rin, Rout;
  logic [4:0]  ALU_Control;
  logic        run;
  logic        illegal;

  modport master (
    input  IR, stop,
    output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           Read, Gra, Grb, Grc, Rin, Rout, ALU_Control, run, illegal
  );

  modport slave (
    output IR, stop,
    input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           Read, Gra, Grb, Grc, Rin, Rout, ALU_Control, run, illegal
  );
endinterface

// File: rtl/alu_rtype_control_unit.sv
// Hardwired control sequencer for the Datapath.
// It fetches each instruction in T0-T2 and executes R-format ALU ops
// "op Ra,Rb,Rc" in T3-T5.
// Ports:
//   clk : system clock; all state changes happen on the rising edge.
//   clr : asynchronous, active-low reset. While clr=0, every output is 0.
//   dp  : control/Datapath bundle (master side). It carries IR and stop in,
//         and carries the bus-drive strobes, register-load strobes, Read,
//         Gra/Grb/Grc, Rin/Rout, ALU_Control, run and the sticky illegal flag out.
// The outputs are a decode of the registered state. T3 also looks at the IR
// opcode, because IR is only loaded at the end of T2.
module alu_rtype_control_unit #(
  parameter logic [4:0]  INC_OP     = 5'd12,
  parameter logic [4:0]  ALU_OP_MIN = 5'd3,
  parameter logic [4:0]  ALU_OP_MAX = 5'd11,
  parameter logic [4:0]  NOP_OP     = 5'd26,
  parameter logic [4:0]  HALT_OP    = 5'd27,
  parameter int unsigned MEM_WAIT   = 0
) (
  input  logic                      clk,
  input  logic                      clr,
  alu_rtype_control_unit_if.master  dp
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, STOPPED, HALTED
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       illegal_q;
  logic [4:0] opcode;
  logic       is_alu, is_nop, is_halt;

  always_comb begin
    opcode  = dp.IR[31:27];
    is_alu  = (opcode >= ALU_OP_MIN) && (opcode <= ALU_OP_MAX);
    is_nop  = (opcode == NOP_OP);
    is_halt = (opcode == HALT_OP);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= T0;
        T0: begin
          state    <= T1;
          wait_cnt <= '0;
        end
        T1: begin
          if (wait_cnt == WAIT_LAST) state <= T2;
          else                       wait_cnt <= wait_cnt + 4'd1;
        end
        T2: state <= T3;
        T3: begin
          if (is_alu)      state <= T4;
          else if (is_nop) state <= dp.stop ? STOPPED : T0;
          else begin
            state <= HALTED;
            if (!is_halt) illegal_q <= 1'b1;
          end
        end
        T4:      state <= T5;
        T5:      state <= dp.stop ? STOPPED : T0;
        STOPPED: if (!dp.stop) state <= T0;
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dp.PCout       = 1'b0;
    dp.Zlowout     = 1'b0;
    dp.MDRout      = 1'b0;
    dp.MARin       = 1'b0;
    dp.Zin         = 1'b0;
    dp.PCin        = 1'b0;
    dp.MDRin       = 1'b0;
    dp.IRin        = 1'b0;
    dp.Yin         = 1'b0;
    dp.Read        = 1'b0;
    dp.Gra         = 1'b0;
    dp.Grb         = 1'b0;
    dp.Grc         = 1'b0;
    dp.Rin         = 1'b0;
    dp.Rout        = 1'b0;
    dp.ALU_Control = '0;
    dp.run         = (state == T0) || (state == T1) || (state == T2) ||
                     (state == T3) || (state == T4) || (state == T5);
    dp.illegal     = illegal_q;
    case (state)
      T0: begin
        dp.PCout       = 1'b1;
        dp.MARin       = 1'b1;
        dp.Zin         = 1'b1;
        dp.ALU_Control = INC_OP;
      end
      T1: begin
        dp.Read  = 1'b1;
        dp.MDRin = 1'b1;
        // The incremented PC is written back only once, even when the read is stretched.
        if (wait_cnt == 4'd0) begin
          dp.Zlowout = 1'b1;
          dp.PCin    = 1'b1;
        end
      end
      T2: begin
        dp.MDRout = 1'b1;
        dp.IRin   = 1'b1;
      end
      T3: begin
        if (is_alu) begin
          dp.Grb  = 1'b1;
          dp.Rout = 1'b1;
          dp.Yin  = 1'b1;
        end
      end
      T4: begin
        dp.Grc         = 1'b1;
        dp.Rout        = 1'b1;
        dp.Zin         = 1'b1;
        dp.ALU_Control = opcode;
      end
      T5: begin
        dp.Zlowout = 1'b1;
        dp.Gra     = 1'b1;
        dp.Rin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
